// File: rtl/tv_response_checker.sv
// Golden-table response checker: loads a DEPTH-entry single-bit golden table, then
// scores a stream of (stimulus, response) records for mismatches and stimulus coverage.
module tv_response_checker #(
    parameter int NW = 3,
    parameter int CW = 16
) (
    input  logic          CK,
    input  logic          reset,
    input  logic          start,
    input  logic          load_valid,
    input  logic          load_data,
    output logic          load_ready,
    input  logic          obs_valid,
    input  logic [NW-1:0] obs_stim,
    input  logic          obs_resp,
    input  logic          obs_last,
    output logic          obs_ready,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          cov_full,
    output logic [CW-1:0] mismatch_count,
    output logic          first_mm_valid,
    output logic [NW-1:0] first_mm_stim
);
    localparam int DEPTH = 2 ** NW;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    state_t          state_reg, state_next;
    logic [NW-1:0]   addr_reg;
    logic [DEPTH-1:0] golden_reg;
    logic [DEPTH-1:0] golden_we;
    logic [DEPTH-1:0] cov_reg;
    logic [DEPTH-1:0] cov_hit;
    logic [CW-1:0]   mm_count_reg;
    logic            first_mm_valid_reg;
    logic [NW-1:0]   first_mm_stim_reg;

    logic load_fire;
    logic last_beat;
    logic obs_fire;
    logic mismatch;
    logic cov_complete;
    logic enter_check;

    assign load_fire    = (state_reg == LOAD) && load_valid;
    assign last_beat    = load_fire && (addr_reg == NW'(DEPTH - 1));
    assign obs_fire     = (state_reg == CHECK) && obs_valid;
    assign mismatch     = obs_fire && (obs_resp != golden_reg[obs_stim]);
    assign cov_complete = &cov_hit;
    // Per-run statistics restart whenever CHECK is entered, from either LOAD or DONE.
    assign enter_check  = last_beat || ((state_reg == DONE) && start);

    // Per-entry write enables for the golden table and the coverage bitmap
    // as it will look including the record currently being accepted.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign golden_we[gi] = load_fire && (addr_reg == NW'(gi));
            assign cov_hit[gi]   = cov_reg[gi] || (obs_stim == NW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (last_beat) state_next = CHECK;
            CHECK:   if (obs_fire && (obs_last || cov_complete)) state_next = DONE;
            DONE:    if (start) state_next = CHECK;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CK) begin
        if (reset || (state_reg == IDLE)) begin
            addr_reg <= '0;
        end else if (load_fire) begin
            addr_reg <= addr_reg + NW'(1);
        end
    end

    // Golden contents need no reset: every path out of IDLE rewrites all entries.
    always_ff @(posedge CK) begin
        golden_reg <= (golden_reg & ~golden_we) | ({DEPTH{load_data}} & golden_we);
    end

    always_ff @(posedge CK) begin
        if (reset || enter_check) begin
            cov_reg            <= '0;
            mm_count_reg       <= '0;
            first_mm_valid_reg <= 1'b0;
            first_mm_stim_reg  <= '0;
        end else begin
            if (obs_fire) begin
                cov_reg <= cov_hit;
            end
            if (mismatch && (mm_count_reg != '1)) begin
                mm_count_reg <= mm_count_reg + CW'(1);
            end
            if (mismatch && !first_mm_valid_reg) begin
                first_mm_valid_reg <= 1'b1;
                first_mm_stim_reg  <= obs_stim;
            end
        end
    end

    assign load_ready     = (state_reg == LOAD);
    assign obs_ready      = (state_reg == CHECK);
    assign busy           = (state_reg == LOAD) || (state_reg == CHECK);
    assign done           = (state_reg == DONE);
    assign cov_full       = &cov_reg;
    assign mismatch_count = mm_count_reg;
    assign first_mm_valid = first_mm_valid_reg;
    assign first_mm_stim  = first_mm_stim_reg;
    assign pass           = done && (mm_count_reg == '0) && cov_full;

endmodule

// File: tb/tb_tv_response_checker.sv
// Directed bench for tv_response_checker: load, sweep, mismatch, early-last,
// repeated stimuli, mid-run reset and rerun scenarios with hand-computed results.
module tb_tv_response_checker;
    logic        CK;
    logic        reset;
    logic        start;
    logic        load_valid;
    logic        load_data;
    logic        load_ready;
    logic        obs_valid;
    logic [2:0]  obs_stim;
    logic        obs_resp;
    logic        obs_last;
    logic        obs_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic        cov_full;
    logic [15:0] mismatch_count;
    logic        first_mm_valid;
    logic [2:0]  first_mm_stim;

    int checks;
    int errors;
    logic [7:0] gold;

    tv_response_checker #(.NW(3), .CW(16)) dut (
        .CK(CK), .reset(reset), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .obs_valid(obs_valid), .obs_stim(obs_stim), .obs_resp(obs_resp),
        .obs_last(obs_last), .obs_ready(obs_ready), .busy(busy), .done(done),
        .pass(pass), .cov_full(cov_full), .mismatch_count(mismatch_count),
        .first_mm_valid(first_mm_valid), .first_mm_stim(first_mm_stim)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
        $display("check %-24s observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_load_ready"}, 32'(load_ready), 0);
        check({tag, "_obs_ready"}, 32'(obs_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_cov_full"}, 32'(cov_full), 0);
        check({tag, "_mm_count"}, 32'(mismatch_count), 0);
        check({tag, "_fmm_valid"}, 32'(first_mm_valid), 0);
        check({tag, "_fmm_stim"}, 32'(first_mm_stim), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] s, input logic r, input logic l);
        obs_valid = 1'b1;
        obs_stim  = s;
        obs_resp  = r;
        obs_last  = l;
        tick();
        obs_valid = 1'b0;
        obs_last  = 1'b0;
    endtask

    // Full 8-beat load of gold, with one stall cycle after beat 3.
    task automatic load_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = gold[i];
            tick();
            if (i == 3) begin
                load_valid = 1'b0;
                tick();
                check({tag, "_stall_ready"}, 32'(load_ready), 1);
            end
            if (i == 6) check({tag, "_obs_ready_b7"}, 32'(obs_ready), 0);
        end
        load_valid = 1'b0;
        check({tag, "_obs_ready"}, 32'(obs_ready), 1);
        check({tag, "_load_ready"}, 32'(load_ready), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        gold = 8'b1001_0110;  // addr0..7 = 0,1,1,0,1,0,0,1
        reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = 1'b0;
        obs_valid = 1'b0; obs_stim = '0; obs_resp = 1'b0; obs_last = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        // Load the golden table
        pulse_start();
        check("load_state_ready", 32'(load_ready), 1);
        check("load_state_busy", 32'(busy), 1);
        load_table("load1");

        // Full matching sweep
        for (int i = 0; i < 8; i++) begin
            send(3'(i), gold[i], 1'b0);
            if (i == 6) check("sweep1_done_early", 32'(done), 0);
        end
        check("sweep1_done", 32'(done), 1);
        check("sweep1_mm", 32'(mismatch_count), 0);
        check("sweep1_cov", 32'(cov_full), 1);
        check("sweep1_pass", 32'(pass), 1);
        check("sweep1_fmm_valid", 32'(first_mm_valid), 0);
        check("sweep1_busy", 32'(busy), 0);
        send(3'd0, ~gold[0], 1'b0);  // ignored in DONE
        check("done_ignores_obs_mm", 32'(mismatch_count), 0);
        check("done_ignores_obs_pass", 32'(pass), 1);

        // Rerun with mismatches at stim 2 and 5
        pulse_start();
        check("run2_obs_ready", 32'(obs_ready), 1);
        check("run2_cleared_cov", 32'(cov_full), 0);
        check("run2_cleared_done", 32'(done), 0);
        for (int i = 0; i < 8; i++) begin
            send(3'(i), (i == 2 || i == 5) ? ~gold[i] : gold[i], 1'b0);
            if (i == 2) begin
                check("run2_mm_after2", 32'(mismatch_count), 1);
                check("run2_fmm_valid_after2", 32'(first_mm_valid), 1);
                check("run2_fmm_stim_after2", 32'(first_mm_stim), 2);
            end
        end
        check("run2_mm", 32'(mismatch_count), 2);
        check("run2_fmm_stim", 32'(first_mm_stim), 2);
        check("run2_fmm_valid", 32'(first_mm_valid), 1);
        check("run2_done", 32'(done), 1);
        check("run2_cov", 32'(cov_full), 1);
        check("run2_pass", 32'(pass), 0);

        // Early obs_last
        pulse_start();
        check("run3_cleared_mm", 32'(mismatch_count), 0);
        check("run3_cleared_fmm", 32'(first_mm_valid), 0);
        send(3'd0, gold[0], 1'b0);
        send(3'd1, gold[1], 1'b0);
        check("run3_not_done", 32'(done), 0);
        send(3'd2, gold[2], 1'b1);
        check("run3_done", 32'(done), 1);
        check("run3_cov", 32'(cov_full), 0);
        check("run3_pass", 32'(pass), 0);
        check("run3_mm", 32'(mismatch_count), 0);

        // Repeated mismatching stim 3, with stray load beats that must not alter the table
        pulse_start();
        load_valid = 1'b1;
        load_data  = ~gold[3];
        for (int i = 0; i < 4; i++) send(3'd3, ~gold[3], 1'b0);
        load_valid = 1'b0;
        check("run4_mm_rep", 32'(mismatch_count), 4);
        check("run4_fmm_stim", 32'(first_mm_stim), 3);
        for (int i = 0; i < 8; i++) begin
            send(3'(i), gold[i], 1'b0);
            if (i == 6) check("run4_done_early", 32'(done), 0);
        end
        check("run4_done", 32'(done), 1);
        check("run4_mm", 32'(mismatch_count), 4);
        check("run4_cov", 32'(cov_full), 1);
        check("run4_pass", 32'(pass), 0);

        // Replay from DONE; golden retained; obs_last coincides with coverage completion
        pulse_start();
        check("run5_cleared_mm", 32'(mismatch_count), 0);
        load_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_data = ~gold[i];
            send(3'(i), gold[i], i == 7);
        end
        load_valid = 1'b0;
        check("run5_done", 32'(done), 1);
        check("run5_mm", 32'(mismatch_count), 0);
        check("run5_pass", 32'(pass), 1);
        tick();
        check("run5_done_hold", 32'(done), 1);
        check("run5_pass_hold", 32'(pass), 1);

        // Reset mid-CHECK overrides start and valids
        pulse_start();
        for (int i = 0; i < 4; i++) send(3'(i), ~gold[i], 1'b0);
        check("run6_mm_before_reset", 32'(mismatch_count), 4);
        reset = 1'b1; start = 1'b1; obs_valid = 1'b1; obs_stim = 3'd4; load_valid = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; obs_valid = 1'b0; load_valid = 1'b0;
        check_idle("midreset");
        tick();
        check("idle_stays", 32'(busy), 0);

        // Reload with the inverted table, then verify it took effect
        gold = ~gold;
        pulse_start();
        load_table("load2");
        for (int i = 0; i < 8; i++) send(3'(i), gold[i], 1'b0);
        check("reload_done", 32'(done), 1);
        check("reload_mm", 32'(mismatch_count), 0);
        check("reload_pass", 32'(pass), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tv_response_checker.md
# tv_response_checker

Synthesizable consumer of stimulus/response vector records for trojan-detection runs. It loads a golden single-bit response table indexed by stimulus value. It then accepts a stream of (stimulus, observed response) pairs, such as those a bench sweeps through a DUT. It counts mismatches, records the first offending stimulus, and tracks stimulus coverage until every code has been seen or the stream ends.

## Interface
- NW, 3, stimulus width in bits; table depth DEPTH = 2**NW
- CW, 16, mismatch counter width (saturating)

- CK  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  one-cycle pulse; IDLE→LOAD, or DONE→CHECK (rerun with same golden table)
- load_valid  input  1  golden bit present on load_data
- load_data  input  1  golden response for current load address
- load_ready  output  1  high in LOAD
- obs_valid  input  1  observation record present
- obs_stim  input  NW  stimulus applied to DUT
- obs_resp  input  1  DUT output observed for obs_stim
- obs_last  input  1  marks final record of stream (qualified by obs_valid)
- obs_ready  output  1  high in CHECK
- busy  output  1  high in LOAD or CHECK
- done  output  1  high in DONE
- pass  output  1  done & mismatch_count==0 & cov_full
- cov_full  output  1  every stimulus code 0..DEPTH-1 seen at least once in current run
- mismatch_count  output  CW  number of accepted records with obs_resp ≠ golden[obs_stim]
- first_mm_valid  output  1  at least one mismatch recorded this run
- first_mm_stim  output  NW  obs_stim of first mismatching record

## Operation
- States: IDLE, LOAD, CHECK, DONE.
- IDLE: all outputs low or zero. start → LOAD; load address cleared.
- LOAD: on load_valid, golden[addr] <= load_data and addr increments.
  - The write at addr = DEPTH-1 moves to CHECK on the next edge.
  - Entering CHECK clears the coverage bitmap, mismatch_count, first_mm_valid and first_mm_stim.
- CHECK: a record is accepted when obs_valid & obs_ready.
  - Each accepted record sets cov[obs_stim].
  - Each accepted record compares obs_resp against golden[obs_stim].
  - A mismatch increments mismatch_count, saturating at 2**CW-1.
  - The first mismatch of a run latches first_mm_stim and sets first_mm_valid. Later mismatches do not overwrite them.
  - Repeated stimuli are legal and compared and counted every time.
- CHECK→DONE after an accepted record either carries obs_last or completes coverage (all cov bits set, including the current one). Either condition alone suffices.
- DONE: all result outputs hold.
  - start → CHECK, which clears the per-run statistics and keeps the golden table.
  - obs_valid in DONE is ignored.
- start is ignored in LOAD and CHECK. load_valid outside LOAD is ignored.
- reset: state ← IDLE; counters, bitmap and first-mismatch registers cleared. Golden table contents are don't-care because IDLE always forces a reload.

## Timing
- Reset values: load_ready=0, obs_ready=0, busy=0, done=0, pass=0, cov_full=0, mismatch_count=0, first_mm_valid=0, first_mm_stim=0.
- LOAD takes exactly DEPTH accepted load beats. Gaps (load_valid low) stall the load with no limit.
- obs_ready is high on the first cycle after the final load beat.
- An observation record accepted at edge t is reflected at t+1 in:
  - mismatch_count
  - first_mm_*
  - cov_full
  - done
- Throughput is one record per cycle. No backpressure applies inside CHECK.
- pass is combinational from registered state. Valid whenever done=1.
- A reset asserted mid-LOAD or mid-CHECK takes effect at the next edge and overrides start and any valid.
- obs_last on a record that also completes coverage produces a single transition to DONE.

## Test plan
- Load NW=3, golden=01101001 (addr0..7 = 0,1,1,0,1,0,0,1). Feed stim 0..7 with matching responses → done at cycle after stim 7; mismatch_count=0, cov_full=1, pass=1.
- Same golden. Feed stim 0..7 with resp inverted at stim 2 and stim 5 → mismatch_count=2, first_mm_stim=2, first_mm_valid=1, pass=0.
- Feed stim 0,1,2 with obs_last on stim 2, all matching → done=1, cov_full=0, pass=0, mismatch_count=0.
- Feed stim 3 four times (mismatching each time), then 0..7 matching → mismatch_count=4, first_mm_stim=3, done after stim 7 completes coverage.
- Assert reset in CHECK after 4 records → next cycle IDLE, all outputs zero. start then requires a full 8-beat reload before obs_ready rises.
- From DONE, pulse start and replay sweep with no mismatches → stats cleared on entry, golden retained, pass=1. load_valid pulses during CHECK have no effect.
